// File: rtl/controle_pintura_if.sv
// Bundle of the two requester handshakes and the framebuffer write port
// used by the paint-engine controller. The controller takes the slave
// modport; whatever drives the requests and the RAM side takes master.
interface controle_pintura_if #(
  parameter int COLOR_W = 12
);
  // Requester 0
  logic               req0;
  logic [10:0]        x0;
  logic [10:0]        y0;
  logic [6:0]         size0;
  logic [COLOR_W-1:0] color0;
  logic               grant0;
  logic               done0;

  // Requester 1
  logic               req1;
  logic [10:0]        x1;
  logic [10:0]        y1;
  logic [6:0]         size1;
  logic [COLOR_W-1:0] color1;
  logic               grant1;
  logic               done1;

  // Framebuffer write port
  logic               wr_en;
  logic [10:0]        wr_x;
  logic [10:0]        wr_y;
  logic [COLOR_W-1:0] wr_color;
  logic               wr_ready;

  // Status
  logic               busy;

  modport master (
    output req0, x0, y0, size0, color0,
    output req1, x1, y1, size1, color1,
    output wr_ready,
    input  grant0, done0, grant1, done1,
    input  wr_en, wr_x, wr_y, wr_color,
    input  busy
  );

  modport slave (
    input  req0, x0, y0, size0, color0,
    input  req1, x1, y1, size1, color1,
    input  wr_ready,
    output grant0, done0, grant1, done1,
    output wr_en, wr_x, wr_y, wr_color,
    output busy
  );
endinterface

// File: rtl/controle_pintura.sv
// Paint-engine controller: round-robin arbitration between two square-paint
// requesters, then a row-major raster of the granted SIZE x SIZE square onto
// the framebuffer write port, one pixel per accepted write, with off-screen
// pixels skipped at one cycle each. Every output is a register; the next
// output values are derived from the next FSM state and next pixel so that
// the grant pulse and the first write appear in the cycle after the request
// edge.
module controle_pintura #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COLOR_W = 12
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  controle_pintura_if.slave  s_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // Round-robin owner: index of the most recently granted requester. It also
  // tells DONE which requester to pulse.
  logic               r_last;

  // Square parameters latched on the grant edge. Coordinates carry one
  // extra bit so that bx+sz-1 (up to 2047+126) never wraps.
  logic [11:0]        r_bx;
  logic [11:0]        r_by;
  logic [6:0]         r_sz;
  logic [COLOR_W-1:0] r_col;

  // Current raster position.
  logic [11:0]        r_cx;
  logic [11:0]        r_cy;
  logic [11:0]        w_cx_nxt;
  logic [11:0]        w_cy_nxt;

  // Registered outputs.
  logic               r_grant0;
  logic               r_grant1;
  logic               r_done0;
  logic               r_done1;
  logic               r_wr_en;
  logic [10:0]        r_wr_x;
  logic [10:0]        r_wr_y;
  logic [COLOR_W-1:0] r_wr_color;
  logic               r_busy;

  // Arbitration and raster helpers.
  logic               w_take;
  logic               w_sel1;
  logic               w_grant_edge;
  logic [11:0]        w_bx_in;
  logic [11:0]        w_by_in;
  logic [6:0]         w_sz_in;
  logic [COLOR_W-1:0] w_col_in;
  logic [11:0]        w_xend;
  logic [11:0]        w_yend;
  logic               w_vis;
  logic               w_adv;
  logic               w_vis_nxt;
  logic               w_done_nxt;
  logic [COLOR_W-1:0] w_col_nxt;

  // A tie goes to the requester that was not served last; a lone request
  // always wins.
  assign w_take       = s_bus.req0 | s_bus.req1;
  assign w_sel1       = s_bus.req1 & (~s_bus.req0 | ~r_last);
  assign w_grant_edge = (r_state == S_IDLE) && w_take;

  assign w_bx_in  = {1'b0, (w_sel1 ? s_bus.x1 : s_bus.x0)};
  assign w_by_in  = {1'b0, (w_sel1 ? s_bus.y1 : s_bus.y0)};
  assign w_sz_in  = w_sel1 ? s_bus.size1  : s_bus.size0;
  assign w_col_in = w_sel1 ? s_bus.color1 : s_bus.color0;

  // Last column/row of the square; only consulted in SCAN, where sz >= 1.
  assign w_xend = r_bx + {5'd0, r_sz} - 12'd1;
  assign w_yend = r_by + {5'd0, r_sz} - 12'd1;

  // A visible pixel waits for the framebuffer; a clipped one moves on at once.
  assign w_vis = (r_cx < 12'(H_RES)) && (r_cy < 12'(V_RES));
  assign w_adv = ~w_vis | s_bus.wr_ready;

  // Next state and next raster position.
  always_comb begin
    w_state_nxt = r_state;
    w_cx_nxt    = r_cx;
    w_cy_nxt    = r_cy;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_cx_nxt    = w_bx_in;
          w_cy_nxt    = w_by_in;
          w_state_nxt = (w_sz_in == 7'd0) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_adv) begin
          if (r_cx == w_xend) begin
            if (r_cy == w_yend) begin
              w_state_nxt = S_DONE;
            end else begin
              w_cx_nxt = r_bx;
              w_cy_nxt = r_cy + 12'd1;
            end
          end else begin
            w_cx_nxt = r_cx + 12'd1;
          end
        end
      end
      S_DONE: begin
        // An empty square enters DONE straight from IDLE with its grant
        // pulse showing, so it spends one more cycle here to put the done
        // pulse in the following cycle.
        if (r_done0 | r_done1) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The done pulse fires on every entry into (or extra cycle of) DONE except
  // the direct IDLE->DONE step of an empty square.
  assign w_done_nxt = (w_state_nxt == S_DONE) && (r_state != S_IDLE);
  assign w_vis_nxt  = (w_state_nxt == S_SCAN) &&
                      (w_cx_nxt < 12'(H_RES)) && (w_cy_nxt < 12'(V_RES));
  assign w_col_nxt  = w_grant_edge ? w_col_in : r_col;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the winning request's fields and update the round-robin owner.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
      r_bx   <= '0;
      r_by   <= '0;
      r_sz   <= '0;
      r_col  <= '0;
    end else if (w_grant_edge) begin
      r_last <= w_sel1;
      r_bx   <= w_bx_in;
      r_by   <= w_by_in;
      r_sz   <= w_sz_in;
      r_col  <= w_col_in;
    end
  end

  // Raster position register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cx <= '0;
      r_cy <= '0;
    end else begin
      r_cx <= w_cx_nxt;
      r_cy <= w_cy_nxt;
    end
  end

  // Output registers, loaded with the values belonging to the next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant0   <= 1'b0;
      r_grant1   <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_x     <= '0;
      r_wr_y     <= '0;
      r_wr_color <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_grant0 <= w_grant_edge & ~w_sel1;
      r_grant1 <= w_grant_edge &  w_sel1;
      r_done0  <= w_done_nxt & ~r_last;
      r_done1  <= w_done_nxt &  r_last;
      r_wr_en  <= w_vis_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      // Coordinates only move for visible pixels; a visible pixel fits in
      // 11 bits because it is below H_RES/V_RES.
      if (w_vis_nxt) begin
        r_wr_x     <= w_cx_nxt[10:0];
        r_wr_y     <= w_cy_nxt[10:0];
        r_wr_color <= w_col_nxt;
      end
    end
  end

  assign s_bus.grant0   = r_grant0;
  assign s_bus.grant1   = r_grant1;
  assign s_bus.done0    = r_done0;
  assign s_bus.done1    = r_done1;
  assign s_bus.wr_en    = r_wr_en;
  assign s_bus.wr_x     = r_wr_x;
  assign s_bus.wr_y     = r_wr_y;
  assign s_bus.wr_color = r_wr_color;
  assign s_bus.busy     = r_busy;

endmodule

// File: tb/tb_controle_pintura.sv
// Directed bench for controle_pintura: single square, round-robin tie,
// write stalls, screen-edge clipping, empty square and mid-square reset.
module tb_controle_pintura;

  logic clk;
  logic rst_n;

  controle_pintura_if #(.COLOR_W(12)) bus ();

  controle_pintura #(
    .H_RES   (640),
    .V_RES   (480),
    .COLOR_W (12)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .s_bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-scenario log; cycle 1 is the cycle after the arbitration edge.
  int g_who[$];
  int g_cyc[$];
  int d_who[$];
  int d_cyc[$];
  int w_xy[$];
  int w_col[$];
  int w_cyc[$];
  int acc_n;
  bit busy_a[64];
  bit hold_reqs;
  int stall_lo;
  int stall_hi;
  int d0_seen;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int at_q(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  function automatic int xy(input int x, input int y);
    return x * 4096 + y;
  endfunction

  task automatic clear_log();
    g_who.delete(); g_cyc.delete(); d_who.delete(); d_cyc.delete();
    w_xy.delete(); w_col.delete(); w_cyc.delete();
    acc_n = 0;
    for (int i = 0; i < 64; i++) busy_a[i] = 1'b0;
  endtask

  // Run n cycles, sampling outputs on the falling edge, then driving the
  // ready line for the rising edge that ends that cycle.
  task automatic run(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.wr_en) begin
        w_xy.push_back(xy(int'(bus.wr_x), int'(bus.wr_y)));
        w_col.push_back(int'(bus.wr_color));
        w_cyc.push_back(i);
      end
      if (bus.grant0) begin g_who.push_back(0); g_cyc.push_back(i); end
      if (bus.grant1) begin g_who.push_back(1); g_cyc.push_back(i); end
      if (bus.done0) begin
        d_who.push_back(0); d_cyc.push_back(i);
        if (!hold_reqs) bus.req0 = 1'b0;
      end
      if (bus.done1) begin
        d_who.push_back(1); d_cyc.push_back(i);
        if (!hold_reqs) bus.req1 = 1'b0;
      end
      busy_a[i] = bus.busy;
      bus.wr_ready = !(i >= stall_lo && i <= stall_hi);
      if (bus.wr_en && bus.wr_ready) acc_n++;
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.size0 = '0; bus.color0 = '0;
    bus.req1 = 1'b0; bus.x1 = '0; bus.y1 = '0; bus.size1 = '0; bus.color1 = '0;
    bus.wr_ready = 1'b1;
    hold_reqs = 1'b0;
    stall_lo = 100; stall_hi = 0;
    clear_log();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_grant0", int'(bus.grant0), 0);
    chk("rst_done0", int'(bus.done0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 3x3 square at (10,20)
    bus.req0 = 1'b1; bus.x0 = 11'd10; bus.y0 = 11'd20; bus.size0 = 7'd3;
    bus.color0 = 12'hABC;
    clear_log();
    run(12);
    chk("s1_grant_n", g_who.size(), 1);
    chk("s1_grant_who", at_q(g_who, 0), 0);
    chk("s1_grant_cyc", at_q(g_cyc, 0), 1);
    chk("s1_wr_n", w_xy.size(), 9);
    k = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        chk("s1_wr_xy", at_q(w_xy, k), xy(10 + c, 20 + r));
        chk("s1_wr_cyc", at_q(w_cyc, k), k + 1);
        k++;
      end
    end
    chk("s1_color", at_q(w_col, 0), 12'hABC);
    chk("s1_done_n", d_who.size(), 1);
    chk("s1_done_cyc", at_q(d_cyc, 0), 10);
    chk("s1_busy10", int'(busy_a[10]), 1);
    chk("s1_busy11", int'(busy_a[11]), 0);

    // Empty square on requester 1
    bus.req1 = 1'b1; bus.x1 = 11'd5; bus.y1 = 11'd5; bus.size1 = 7'd0;
    bus.color1 = 12'h123;
    clear_log();
    run(5);
    chk("z_grant_who", at_q(g_who, 0), 1);
    chk("z_grant_cyc", at_q(g_cyc, 0), 1);
    chk("z_done_who", at_q(d_who, 0), 1);
    chk("z_done_cyc", at_q(d_cyc, 0), 2);
    chk("z_wr_n", w_xy.size(), 0);
    chk("z_busy2", int'(busy_a[2]), 1);
    chk("z_busy3", int'(busy_a[3]), 0);

    // Continuous tie: 0,1,0,1 with no interleaving
    bus.req0 = 1'b1; bus.x0 = 11'd0;   bus.y0 = 11'd0;  bus.size0 = 7'd2;
    bus.color0 = 12'h111;
    bus.req1 = 1'b1; bus.x1 = 11'd100; bus.y1 = 11'd50; bus.size1 = 7'd1;
    bus.color1 = 12'h222;
    hold_reqs = 1'b1;
    clear_log();
    run(16);
    chk("rr_grant_n", g_who.size(), 4);
    chk("rr_g0_who", at_q(g_who, 0), 0);
    chk("rr_g0_cyc", at_q(g_cyc, 0), 1);
    chk("rr_g1_who", at_q(g_who, 1), 1);
    chk("rr_g1_cyc", at_q(g_cyc, 1), 7);
    chk("rr_g2_who", at_q(g_who, 2), 0);
    chk("rr_g2_cyc", at_q(g_cyc, 2), 10);
    chk("rr_g3_who", at_q(g_who, 3), 1);
    chk("rr_g3_cyc", at_q(g_cyc, 3), 16);
    chk("rr_wr_n", w_xy.size(), 10);
    chk("rr_wr3_xy", at_q(w_xy, 3), xy(1, 1));
    chk("rr_wr3_cyc", at_q(w_cyc, 3), 4);
    chk("rr_wr4_xy", at_q(w_xy, 4), xy(100, 50));
    chk("rr_wr4_cyc", at_q(w_cyc, 4), 7);
    chk("rr_wr4_col", at_q(w_col, 4), 12'h222);
    chk("rr_wr5_cyc", at_q(w_cyc, 5), 10);
    chk("rr_d0_cyc", at_q(d_cyc, 0), 5);
    chk("rr_d1_cyc", at_q(d_cyc, 1), 8);
    chk("rr_d2_cyc", at_q(d_cyc, 2), 14);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    hold_reqs = 1'b0;
    clear_log();
    run(4);
    chk("rr_drain_done", at_q(d_who, 0), 1);
    chk("rr_drain_cyc", at_q(d_cyc, 0), 1);
    chk("rr_drain_busy", int'(busy_a[2]), 0);

    // 2x2 square with three stalled cycles on the second pixel
    bus.req0 = 1'b1; bus.x0 = 11'd10; bus.y0 = 11'd20; bus.size0 = 7'd2;
    bus.color0 = 12'h0F0;
    stall_lo = 2; stall_hi = 4;
    clear_log();
    run(10);
    chk("st_wr_cycles", w_xy.size(), 7);
    for (int i = 1; i <= 4; i++) chk("st_hold_xy", at_q(w_xy, i), xy(11, 20));
    chk("st_wr5_xy", at_q(w_xy, 5), xy(10, 21));
    chk("st_wr6_xy", at_q(w_xy, 6), xy(11, 21));
    chk("st_accepted", acc_n, 4);
    chk("st_done_cyc", at_q(d_cyc, 0), 8);
    stall_lo = 100; stall_hi = 0;

    // Corner square; ready low on clipped pixels must not slow it down
    bus.req0 = 1'b1; bus.x0 = 11'd638; bus.y0 = 11'd478; bus.size0 = 7'd4;
    bus.color0 = 12'hF00;
    stall_lo = 3; stall_hi = 4;
    clear_log();
    run(18);
    chk("cl_wr_n", w_xy.size(), 4);
    chk("cl_wr0", at_q(w_xy, 0), xy(638, 478));
    chk("cl_wr1", at_q(w_xy, 1), xy(639, 478));
    chk("cl_wr2", at_q(w_xy, 2), xy(638, 479));
    chk("cl_wr3", at_q(w_xy, 3), xy(639, 479));
    chk("cl_cyc1", at_q(w_cyc, 1), 2);
    chk("cl_cyc2", at_q(w_cyc, 2), 5);
    chk("cl_cyc3", at_q(w_cyc, 3), 6);
    chk("cl_accepted", acc_n, 4);
    chk("cl_busy16", int'(busy_a[16]), 1);
    chk("cl_done_cyc", at_q(d_cyc, 0), 17);
    chk("cl_busy18", int'(busy_a[18]), 0);
    stall_lo = 100; stall_hi = 0;

    // Reset during pixel 5 of a 4x4 square
    bus.req0 = 1'b1; bus.x0 = 11'd0; bus.y0 = 11'd0; bus.size0 = 7'd4;
    bus.color0 = 12'h5A5;
    clear_log();
    run(4);
    @(negedge clk);
    chk("mr_pix5_en", int'(bus.wr_en), 1);
    chk("mr_pix5_xy", xy(int'(bus.wr_x), int'(bus.wr_y)), xy(0, 1));
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    #1;
    chk("mr_wr_en", int'(bus.wr_en), 0);
    chk("mr_busy", int'(bus.busy), 0);
    chk("mr_wr_xy", xy(int'(bus.wr_x), int'(bus.wr_y)), 0);
    chk("mr_color", int'(bus.wr_color), 0);
    d0_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done0) d0_seen++;
    end
    chk("mr_no_done", d0_seen, 0);
    rst_n = 1'b1;
    bus.req0 = 1'b1; bus.size0 = 7'd1;
    bus.req1 = 1'b1; bus.x1 = 11'd3; bus.y1 = 11'd3; bus.size1 = 7'd1;
    clear_log();
    run(8);
    chk("mr_tie_who", at_q(g_who, 0), 0);
    chk("mr_tie_cyc", at_q(g_cyc, 0), 1);
    chk("mr_next_who", at_q(g_who, 1), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_pintura.md
# controle_pintura

Paint-engine controller that shares the framebuffer write port between two square-paint requesters, for example the cursor overlay and the brush tool. It accepts one request at a time through a req/grant/done handshake and arbitrates round-robin. For the granted request it rasters a SIZE×SIZE square from (x, y), row-major, one pixel per accepted write. Pixels outside the visible screen are clipped. It sits between the input/cursor logic and the framebuffer RAM write port.

## Interface
- H_RES, 640, visible width in pixels; columns ≥ H_RES are clipped
- V_RES, 480, visible height in pixels; rows ≥ V_RES are clipped
- COLOR_W, 12, pixel colour width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- req0, req1  in  1  level request; held high until that requester's done pulse
- x0, y0, x1, y1  in  11  top-left corner of the square; sampled only on the grant edge
- size0, size1  in  7  square side (0–127); sampled on the grant edge
- color0, color1  in  COLOR_W  fill colour; sampled on the grant edge
- grant0, grant1  out  1  one-cycle pulse: request accepted, fields latched
- done0, done1  out  1  one-cycle pulse: square finished
- wr_en  out  1  pixel write valid
- wr_x, wr_y  out  11  pixel coordinate
- wr_color  out  COLOR_W  pixel colour
- wr_ready  in  1  framebuffer accepts the write this cycle when wr_en=1
- busy  out  1  high in SCAN and DONE

## Operation
- All outputs are registered. Reset value of every output is 0. Round-robin pointer `last` resets to 1, so req0 wins the first tie.
- FSM states: IDLE, SCAN, DONE.
- **IDLE:** on the edge where any req is high:
  - select winner k: the sole requester, or on a tie the one ≠ `last`;
  - latch bx=xk, by=yk, sz=sizek, col=colork;
  - set cx=bx, cy=by, last=k;
  - pulse grantk;
  - go to SCAN, or to DONE if sz=0 (no writes).
- **SCAN:**
  - Current pixel (cx, cy) is visible iff cx < H_RES and cy < V_RES.
  - Visible: wr_en=1, wr_x=cx, wr_y=cy, wr_color=col. The pixel advances only on an edge with wr_ready=1. While wr_ready=0, all outputs hold.
  - Clipped: wr_en=0 and the pixel advances unconditionally (one cycle per pixel, ready ignored).
  - Advance rule: if cx == bx+sz−1, then cx=bx and cy=cy+1; else cx=cx+1.
  - When the pixel with cx == bx+sz−1 and cy == by+sz−1 advances, go to DONE.
- **DONE:** donek=1 for one cycle, wr_en=0, return to IDLE.
- Arithmetic: compute end coordinates and comparisons in 12 bits (bx+sz−1 up to 2047+126). No wrap to column 0; overflowing columns are simply clipped.
- Input fields may change freely after the grant edge. req is ignored outside IDLE.
- A req still high in IDLE after its done is re-arbitrated normally, so a continuous pair alternates 0,1,0,1.
- Reset mid-operation: abort immediately, no done pulse, FSM to IDLE, `last`=1.

## Timing
- Arbitration latency: req high at edge E in IDLE → grant pulse and first wr_en in the cycle after E.
- With all pixels visible and wr_ready=1: sz² consecutive wr_en cycles, then done in the next cycle, then IDLE. A waiting request is granted on the edge ending that IDLE cycle.
- Throughput: 1 pixel/cycle. Each wr_ready=0 cycle on a visible pixel adds exactly one cycle.
- Clipped pixels cost one cycle each, with no write.
- grant and done are never high in the same cycle for the same requester, except when sz=0 (grant cycle, then done in the following cycle).

## Test plan
- req0 at x0=10, y0=20, size0=3, color0=0xABC, wr_ready=1 → grant0 1 cycle; writes (10,20),(11,20),(12,20),(10,21)…(12,22), 9 consecutive cycles; done0 on cycle 10; busy low after.
- req0 and req1 both asserted and held → grant0 first, then grant1, then grant0. No writes interleave between squares. `last` alternates.
- size 2 with wr_ready low for 3 cycles on the second pixel → outputs hold (11,20) for those cycles; 4 writes total; done 3 cycles later than the unstalled case.
- x0=638, y0=478, size0=4 → only (638,478),(639,478),(638,479),(639,479) written with wr_en=1; 16 SCAN cycles; done0 on cycle 17.
- size1=0 → grant1, then done1 next cycle, wr_en never high.
- reset pulled low during pixel 5 of a size-4 square → all outputs 0 asynchronously, no done. After release, a tie is granted to req0.
